// File: rtl/multicycle_sequencer_pkg.sv
// multicycle_sequencer_pkg: sequencer state type and sizing helper
package multicycle_sequencer_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} seq_state_t;
  function automatic int cntWidth(int maxVal);
    return maxVal > 1 ? $clog2(maxVal + 1) : 1;
  endfunction
endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: decoded control, memory handshake and sequencer outputs
interface multicycle_sequencer_if #(parameter int CNT_W = 32);
  logic ihit, dhit, DataRead, DataWrite, RegWr, Halt;
  logic imemREN, dmemREN, dmemWEN, IrWEn, PcWEn, RegWEn, halt, bus_err;
  logic [CNT_W-1:0] instr_count, cyc_count;
  modport master(
    input ihit, dhit, DataRead, DataWrite, RegWr, Halt,
    output imemREN, dmemREN, dmemWEN, IrWEn, PcWEn, RegWEn, halt, bus_err, instr_count, cyc_count
  );
  modport slave(
    output ihit, dhit, DataRead, DataWrite, RegWr, Halt,
    input imemREN, dmemREN, dmemWEN, IrWEn, PcWEn, RegWEn, halt, bus_err, instr_count, cyc_count
  );
endinterface

// File: rtl/multicycle_sequencer_wait.sv
// seq_wait_timer: counts memory wait cycles and flags watchdog expiry
module seq_wait_timer
  import multicycle_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic waiting,
  output logic expire
);
  localparam int W = cntWidth(WAIT_MAX);
  logic [W-1:0] waitCnt;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) waitCnt <= '0;
    else waitCnt <= clear ? '0 : waiting ? waitCnt + 1'b1 : waitCnt;
  // Expires on the miss that would take the count to WAIT_MAX; a hit that cycle is not a wait.
  assign expire = WAIT_MAX != 0 && waiting && waitCnt == W'(WAIT_MAX - 1);
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: walks instructions through FETCH/DECODE/EXEC/MEM/WB with counters and watchdog
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input logic CLK,
  input logic nRST,
  multicycle_sequencer_if.master bus
);
  seq_state_t state, nextState;
  logic rdQ, wrQ, haltQ, busErrQ, waiting, expire;
  logic [CNT_W-1:0] instrCount, cycCount;
  assign waiting = (state == FETCH && !bus.ihit) || (state == MEM && !bus.dhit);
  seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) uTimer (
    .CLK(CLK),
    .nRST(nRST),
    .clear(nextState != state),
    .waiting(waiting),
    .expire(expire)
  );
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state      <= FETCH;
      rdQ        <= 1'b0;
      wrQ        <= 1'b0;
      haltQ      <= 1'b0;
      busErrQ    <= 1'b0;
      instrCount <= '0;
      cycCount   <= '0;
    end else begin
      state <= nextState;
      if (state == EXEC) begin
        rdQ <= bus.DataRead & ~bus.DataWrite;
        wrQ <= bus.DataWrite;
      end
      if (nextState == HALT) haltQ <= 1'b1;
      if (expire) busErrQ <= 1'b1;
      if (state == WB) instrCount <= instrCount + 1'b1;
      if (!haltQ) cycCount <= cycCount + 1'b1;
    end
  always_comb begin
    nextState = state == FETCH  ? (bus.ihit ? DECODE : expire ? HALT : FETCH)
              : state == DECODE ? (bus.Halt ? HALT : EXEC)
              : state == EXEC   ? (bus.DataRead | bus.DataWrite ? MEM : WB)
              : state == MEM    ? (bus.dhit ? WB : expire ? HALT : MEM)
              : state == WB     ? FETCH : HALT;
    bus.imemREN     = state == FETCH;
    bus.IrWEn       = state == FETCH && bus.ihit;
    bus.dmemREN     = state == MEM && rdQ;
    bus.dmemWEN     = state == MEM && wrQ;
    bus.PcWEn       = state == WB;
    bus.RegWEn      = state == WB && bus.RegWr;
    bus.halt        = haltQ;
    bus.bus_err     = busErrQ;
    bus.instr_count = instrCount;
    bus.cyc_count   = cycCount;
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed and randomized instruction streams against a per-instruction trace model
module tb_multicycle_sequencer;
  localparam int WMAX = 4;
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;
  multicycle_sequencer_if #(.CNT_W(8)) bus ();
  multicycle_sequencer #(.WAIT_MAX(WMAX), .CNT_W(8)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [7:0] mInstr = '0;
  logic [7:0] mCyc = '0;
  bit mHalt = 1'b0;
  bit mBus = 1'b0;
  bit skip = 1'b0;

  // Expected output vector: {imemREN,dmemREN,dmemWEN,IrWEn,PcWEn,RegWEn,halt,bus_err}
  function automatic logic [7:0] ev(bit im, bit dr, bit dw, bit ir, bit pc, bit rw);
    return {im, dr, dw, ir, pc, rw, mHalt, mBus};
  endfunction

  task automatic chk(logic [7:0] e);
    logic [7:0] got;
    got = {bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.IrWEn, bus.PcWEn, bus.RegWEn, bus.halt, bus.bus_err};
    checks++;
    assert (got === e) else begin errors++; $error("FAIL outs: got %b expected %b", got, e); end
    checks++;
    assert (bus.instr_count === mInstr) else begin errors++; $error("FAIL instr_count: got %0d expected %0d", bus.instr_count, mInstr); end
    checks++;
    assert (bus.cyc_count === mCyc) else begin errors++; $error("FAIL cyc_count: got %0d expected %0d", bus.cyc_count, mCyc); end
  endtask

  task automatic step(bit ih, bit dh, logic [7:0] e);
    if (!skip) @(negedge CLK);
    skip = 1'b0;
    bus.ihit = ih;
    bus.dhit = dh;
    #1 chk(e);
    if (!e[1]) mCyc++;
  endtask

  task automatic doReset();
    nRST = 1'b0;
    bus.ihit = 1'b0;
    bus.dhit = 1'b0;
    mInstr = '0;
    mCyc = '0;
    mHalt = 1'b0;
    mBus = 1'b0;
    #1 chk(ev(1, 0, 0, 0, 0, 0));
    @(negedge CLK);
    nRST = 1'b1;
    skip = 1'b1;
  endtask

  // One instruction: f fetch misses, m data misses, then the fixed F/D/E/(M)/W trace.
  task automatic instr(int f, int m, bit rd, bit wr, bit rw, bit hlt);
    bus.DataRead = rd;
    bus.DataWrite = wr;
    bus.RegWr = rw;
    bus.Halt = hlt;
    for (int i = 0; i < f; i++) begin
      step(0, 0, ev(1, 0, 0, 0, 0, 0));
      if (i + 1 == WMAX) begin mHalt = 1'b1; mBus = 1'b1; return; end
    end
    step(1, 0, ev(1, 0, 0, 1, 0, 0));
    step(0, 0, ev(0, 0, 0, 0, 0, 0));
    if (hlt) begin mHalt = 1'b1; return; end
    step(0, 0, ev(0, 0, 0, 0, 0, 0));
    if (rd | wr) begin
      for (int j = 0; j < m; j++) begin
        step(0, 0, ev(0, rd & ~wr, wr, 0, 0, 0));
        if (j + 1 == WMAX) begin mHalt = 1'b1; mBus = 1'b1; return; end
      end
      step(0, 1, ev(0, rd & ~wr, wr, 0, 0, 0));
    end
    step(0, 0, ev(0, 0, 0, 0, 1, rw));
    mInstr++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ev(0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    bus.ihit = 1'b0;
    bus.dhit = 1'b0;
    bus.DataRead = 1'b0;
    bus.DataWrite = 1'b0;
    bus.RegWr = 1'b0;
    bus.Halt = 1'b0;
    #2 doReset();
    instr(0, 0, 0, 0, 1, 0);
    instr(0, 3, 1, 0, 1, 0);
    instr(0, 1, 1, 1, 0, 0);
    doReset();
    instr(1, 0, 0, 0, 1, 0);
    instr(0, 2, 0, 1, 0, 0);
    instr(0, 0, 0, 0, 0, 1);
    idle(10);
    doReset();
    instr(4, 0, 0, 0, 1, 0);
    idle(3);
    doReset();
    instr(3, 0, 0, 0, 1, 0);
    instr(0, 3, 0, 1, 0, 0);
    instr(0, 4, 1, 0, 1, 0);
    idle(2);
    doReset();
    bus.DataRead = 1'b0;
    bus.DataWrite = 1'b1;
    bus.RegWr = 1'b1;
    bus.Halt = 1'b0;
    step(1, 0, ev(1, 0, 0, 1, 0, 0));
    step(0, 0, ev(0, 0, 0, 0, 0, 0));
    step(0, 0, ev(0, 0, 0, 0, 0, 0));
    step(0, 0, ev(0, 0, 1, 0, 0, 0));
    #2 doReset();
    instr(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 300; k++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), kind == 1 || kind == 3,
            kind >= 2, 1'($urandom_range(0, 1)), 1'b0);
    end
    instr(0, 0, 0, 0, 0, 1);
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
